// File: rtl/wb_stage_if.sv
// MEM/WB bus: instruction results entering the write-back latch and the
// register-file write port leaving it.
interface wb_stage_if #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 32
);
   logic              in_valid;
   logic              stall;
   logic              flush;
   logic [CTRL_W-1:0] ctrl_in;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] pc_inc;
   logic [DATA_W-1:0] imm_ext;
   logic              cond_flag;
   logic [2:0]        wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic              wb_en;

   modport master (
      output in_valid, stall, flush, ctrl_in,
      output alu_result, mem_rdata, pc_inc, imm_ext, cond_flag,
      input  wb_dst, wb_data, wb_en
   );

   modport slave (
      input  in_valid, stall, flush, ctrl_in,
      input  alu_result, mem_rdata, pc_inc, imm_ext, cond_flag,
      output wb_dst, wb_data, wb_en
   );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline latch, write-back source select and halt sequencing.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
   parameter int DATA_W = 16,
   parameter int CTRL_W = 32
) (
   input  logic      clk,
   input  logic      rst,
   wb_stage_if.slave bus,
   output logic      halt_out,
   output logic      halted,
   output logic      err
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [15:0] retire_cnt
`endif
);

   typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_e;

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] mem_q, mem_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic              cond_q, cond_d;

   logic [2:0] wr_sel;
   logic [2:0] src_sel;
   logic       reg_we;
   logic       halt_bit;
   logic       src_legal;
   logic       retire;
   logic       unused_ctrl;

   assign wr_sel      = ctrl_q[2:0];
   assign src_sel     = ctrl_q[5:3];
   assign reg_we      = ctrl_q[6];
   assign halt_bit    = ctrl_q[10];
   assign src_legal   = (src_sel <= 3'd4);
   assign unused_ctrl = ^{ctrl_q[CTRL_W-1:11], ctrl_q[9:7]};

   // Flush only clears valid; a stalled latch keeps everything it holds.
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      alu_d   = alu_q;
      mem_d   = mem_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      cond_d  = cond_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (!bus.stall) begin
         valid_d = bus.in_valid;
         ctrl_d  = bus.ctrl_in;
         alu_d   = bus.alu_result;
         mem_d   = bus.mem_rdata;
         pc_d    = bus.pc_inc;
         imm_d   = bus.imm_ext;
         cond_d  = bus.cond_flag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         alu_q   <= '0;
         mem_q   <= '0;
         pc_q    <= '0;
         imm_q   <= '0;
         cond_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         mem_q   <= mem_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         cond_q  <= cond_d;
      end
   end

   always_comb begin
      bus.wb_data = '0;
      case (src_sel)
         3'd0:    bus.wb_data = alu_q;
         3'd1:    bus.wb_data = mem_q;
         3'd2:    bus.wb_data = pc_q;
         3'd3:    bus.wb_data = imm_q;
         3'd4:    bus.wb_data = {{(DATA_W-1){1'b0}}, cond_q};
         default: bus.wb_data = '0;
      endcase
   end

   // An instruction retires only while running and not held by a stall.
   assign retire     = valid_q & ~bus.stall & (state_q == RUN);
   assign bus.wb_dst = wr_sel;
   assign bus.wb_en  = retire & reg_we & src_legal & ~halt_bit;
   assign err        = retire & reg_we & ~src_legal;
   assign halt_out   = retire & halt_bit;
   assign halted     = (state_q == HALTED);

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:       if (halt_out) state_d = HALT_PEND;
         HALT_PEND: state_d = HALTED;
         HALTED:    state_d = HALTED;
         default:   state_d = RUN;
      endcase
   end

`ifdef WB_RETIRE_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (retire) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign retire_cnt = cnt_q;
`endif

endmodule
